// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: FSM state encoding and default geometry for the replacement controller
package cache_ctrl_pkg;
  localparam int DEF_NUM_WAYS = 8;
  typedef enum logic [2:0] {IDLE, HIT_UPD, VICTIM, WB, FILL, ALLOC, RESP} state_t;
endpackage

// File: rtl/onehot_prio_enc.sv
// onehot_prio_enc: index of the lowest set bit plus a flag for more than one bit set
module onehot_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_multi
);
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) o_idx = i_vec[i] ? W'(i) : o_idx;
  end
  assign o_multi = |(i_vec & (i_vec - N'(1)));
endmodule

// File: rtl/cache_replace_ctrl.sv
// cache_replace_ctrl: sequences hit updates and miss victim writeback/fill/allocate, then responds
module cache_replace_ctrl import cache_ctrl_pkg::*; #(
  parameter int NUM_WAYS  = DEF_NUM_WAYS,
  parameter int WAY_IDX_W = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NUM_WAYS-1:0]  req_hit_way,
  input  logic [NUM_WAYS-1:0]  dirty_ways,
  output logic [NUM_WAYS-1:0]  hit_way_o,
  output logic [NUM_WAYS-1:0]  allocate_way_o,
  input  logic [NUM_WAYS-1:0]  eviction_target_i,
  input  logic                 eviction_ready_i,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [WAY_IDX_W-1:0] wb_way,
  output logic                 fill_valid,
  input  logic                 fill_ready,
  output logic [WAY_IDX_W-1:0] fill_way,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WAY_IDX_W-1:0] resp_way,
  output logic                 resp_hit,
  output logic                 busy,
  output logic                 err_multi
);
  state_t               r_state, w_next;
  logic [WAY_IDX_W-1:0] r_way, w_hit_idx, w_vic_idx;
  logic                 r_hit, r_err, w_hit_multi, w_vic_multi, w_accept, w_capture;
  logic [NUM_WAYS-1:0]  w_way_oh;
  onehot_prio_enc #(.N(NUM_WAYS), .W(WAY_IDX_W)) u_hit_enc (
    .i_vec(req_hit_way), .o_idx(w_hit_idx), .o_multi(w_hit_multi)
  );
  onehot_prio_enc #(.N(NUM_WAYS), .W(WAY_IDX_W)) u_vic_enc (
    .i_vec(eviction_target_i), .o_idx(w_vic_idx), .o_multi(w_vic_multi)
  );
  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_capture = eviction_ready_i && (r_state == VICTIM);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_way   <= '0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (w_accept && w_hit_multi) || (w_capture && w_vic_multi);
      if (w_accept) begin
        r_way <= w_hit_idx;
        r_hit <= |req_hit_way;
      end
      if (w_capture) r_way <= w_vic_idx;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_valid ? (|req_hit_way ? HIT_UPD : VICTIM) : IDLE;
      HIT_UPD: w_next = RESP;
      VICTIM:  w_next = eviction_ready_i ? (dirty_ways[w_vic_idx] ? WB : FILL) : VICTIM;
      WB:      w_next = wb_ready ? FILL : WB;
      FILL:    w_next = fill_ready ? ALLOC : FILL;
      ALLOC:   w_next = RESP;
      RESP:    w_next = resp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  assign w_way_oh       = NUM_WAYS'(1) << r_way;
  assign req_ready      = r_state == IDLE;
  assign busy           = r_state != IDLE;
  assign hit_way_o      = (r_state == HIT_UPD) ? w_way_oh : '0;
  assign allocate_way_o = (r_state == ALLOC) ? w_way_oh : '0;
  assign wb_valid       = r_state == WB;
  assign wb_way         = wb_valid ? r_way : '0;
  assign fill_valid     = r_state == FILL;
  assign fill_way       = fill_valid ? r_way : '0;
  assign resp_valid     = r_state == RESP;
  assign resp_way       = resp_valid ? r_way : '0;
  assign resp_hit       = resp_valid && r_hit;
  assign err_multi      = r_err;
endmodule

// File: tb/tb_cache_replace_ctrl.sv
// tb_cache_replace_ctrl: directed scenarios checked every cycle against a step-queue model
module tb_cache_replace_ctrl;
  localparam int N = 8;
  localparam int K_UPD = 1, K_VIC = 2, K_WB = 3, K_FILL = 4, K_ALLOC = 5, K_RESP = 6;
  typedef struct {int k; int way; bit hit;} step_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [N-1:0] req_hit_way = '0, dirty_ways = '0, hit_way_o, allocate_way_o;
  logic [N-1:0] eviction_target_i = '0;
  logic eviction_ready_i = 1'b0;
  logic wb_valid, wb_ready = 1'b0, fill_valid, fill_ready = 1'b0;
  logic resp_valid, resp_ready = 1'b0, resp_hit, busy, err_multi;
  logic [2:0] wb_way, fill_way, resp_way;
  int n_cmp = 0, n_bad = 0;
  step_t q[$];
  bit m_err = 1'b0, m_live = 1'b0;
  cache_replace_ctrl #(.NUM_WAYS(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_hit_way(req_hit_way), .dirty_ways(dirty_ways), .hit_way_o(hit_way_o),
    .allocate_way_o(allocate_way_o), .eviction_target_i(eviction_target_i),
    .eviction_ready_i(eviction_ready_i), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_way(wb_way), .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_way(fill_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_way(resp_way),
    .resp_hit(resp_hit), .busy(busy), .err_multi(err_multi)
  );
  always #5 clk = ~clk;
  function automatic int lowest(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Model: a transaction is a queue of steps; the front step decides the outputs.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
      m_live = 1'b1;
    end else begin
      m_err = 1'b0;
      if (q.size() == 0) begin
        if (req_valid && req_hit_way != 0) begin
          m_err = $countones(req_hit_way) > 1;
          q.push_back('{K_UPD, lowest(req_hit_way), 1'b1});
          q.push_back('{K_RESP, lowest(req_hit_way), 1'b1});
        end else if (req_valid) q.push_back('{K_VIC, 0, 1'b0});
      end else begin
        case (q[0].k)
          K_VIC: if (eviction_ready_i) begin
            int w;
            w = lowest(eviction_target_i);
            m_err = $countones(eviction_target_i) > 1;
            void'(q.pop_front());
            if (dirty_ways[w]) q.push_back('{K_WB, w, 1'b0});
            q.push_back('{K_FILL, w, 1'b0});
            q.push_back('{K_ALLOC, w, 1'b0});
            q.push_back('{K_RESP, w, 1'b0});
          end
          K_WB:    if (wb_ready) void'(q.pop_front());
          K_FILL:  if (fill_ready) void'(q.pop_front());
          K_RESP:  if (resp_ready) void'(q.pop_front());
          default: void'(q.pop_front());
        endcase
      end
    end
  end
  initial forever begin
    int k, w;
    logic [N-1:0] oh;
    @(negedge clk);
    if (m_live) begin
      k = q.size() ? q[0].k : 0;
      w = q.size() ? q[0].way : 0;
      oh = N'(1) << w;
      chk("req_ready", req_ready, q.size() == 0);
      chk("busy", busy, q.size() != 0);
      chk("hit_way_o", hit_way_o, k == K_UPD ? oh : '0);
      chk("allocate_way_o", allocate_way_o, k == K_ALLOC ? oh : '0);
      chk("wb_valid", wb_valid, k == K_WB);
      chk("wb_way", wb_way, k == K_WB ? w : 0);
      chk("fill_valid", fill_valid, k == K_FILL);
      chk("fill_way", fill_way, k == K_FILL ? w : 0);
      chk("resp_valid", resp_valid, k == K_RESP);
      chk("resp_way", resp_way, k == K_RESP ? w : 0);
      chk("resp_hit", resp_hit, k == K_RESP && q[0].hit);
      chk("err_multi", err_multi, m_err);
    end
  end
  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("idle_after_resp", req_ready, 1);
  endtask
  task automatic miss(logic [N-1:0] tgt, logic [N-1:0] dirty, bit rdy);
    eviction_target_i = tgt;
    dirty_ways = dirty;
    eviction_ready_i = rdy;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_resp_valid", resp_valid, 0);
    req_valid = 1'b1;
    req_hit_way = 8'h10;
    tick();
    req_valid = 1'b0;
    chk("hit_T1_hit_way", hit_way_o, 8'h10);
    chk("hit_T1_ready", req_ready, 0);
    tick();
    chk("hit_T2_hit_way", hit_way_o, 8'h00);
    chk("hit_T2_resp_valid", resp_valid, 1);
    chk("hit_T2_resp_way", resp_way, 4);
    chk("hit_T2_resp_hit", resp_hit, 1);
    tick();
    chk("hit_resp_hold", resp_valid, 1);
    finish_resp();
    req_hit_way = '0;
    miss(8'h04, 8'h00, 1'b1);
    chk("clean_victim_busy", busy, 1);
    tick();
    chk("clean_no_wb", wb_valid, 0);
    chk("clean_fill_way", fill_way, 2);
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    chk("clean_alloc", allocate_way_o, 8'h04);
    tick();
    chk("clean_alloc_once", allocate_way_o, 8'h00);
    chk("clean_resp_way", resp_way, 2);
    chk("clean_resp_hit", resp_hit, 0);
    finish_resp();
    miss(8'h80, 8'h80, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("dirty_wb_valid", wb_valid, 1);
      chk("dirty_wb_way", wb_way, 7);
      if (i < 4) tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("dirty_fill_way", fill_way, 7);
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    chk("dirty_alloc", allocate_way_o, 8'h80);
    tick();
    chk("dirty_resp_way", resp_way, 7);
    finish_resp();
    miss(8'h01, 8'h00, 1'b0);
    wb_ready = 1'b1;
    fill_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("evwait_busy", busy, 1);
      chk("evwait_no_wb", wb_valid, 0);
      chk("evwait_no_fill", fill_valid, 0);
    end
    wb_ready = 1'b0;
    fill_ready = 1'b0;
    eviction_ready_i = 1'b1;
    tick();
    chk("evwait_fill_way0", fill_valid, 1);
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    chk("evwait_alloc", allocate_way_o, 8'h01);
    tick();
    finish_resp();
    req_valid = 1'b1;
    req_hit_way = 8'h0A;
    tick();
    req_valid = 1'b0;
    req_hit_way = '0;
    chk("multi_hit_way", hit_way_o, 8'h02);
    chk("multi_err", err_multi, 1);
    tick();
    chk("multi_err_once", err_multi, 0);
    chk("multi_resp_way", resp_way, 1);
    finish_resp();
    miss(8'h0C, 8'h00, 1'b1);
    tick();
    chk("multi_vic_err", err_multi, 1);
    chk("multi_vic_fill_way", fill_way, 2);
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    tick();
    finish_resp();
    miss(8'h20, 8'h00, 1'b1);
    tick();
    chk("rst_pre_fill", fill_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("rst_fill_dropped", fill_valid, 0);
    rst_n = 1'b1;
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_no_alloc", allocate_way_o, 8'h00);
    chk("rst_no_resp", resp_valid, 0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_replace_ctrl.md
CACHE_REPLACE_CTRL -- requirements
Module: cache_replace_ctrl

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 8, number of cache ways (power of two, >=2).
REQ-002 SHALL have parameter WAY_IDX_W, default $clog2(NUM_WAYS), width of a way index.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port req_valid / req_ready, in/out, 1 each, lookup-result request handshake.
REQ-006 SHALL have port req_hit_way, input, NUM_WAYS, one-hot hit vector; all-zero means miss.
REQ-007 SHALL have port dirty_ways, input, NUM_WAYS, per-way dirty status, sampled when the victim is captured.
REQ-008 SHALL have ports hit_way_o / allocate_way_o, output, NUM_WAYS each, one-cycle one-hot update pulses to the eviction policy.
REQ-009 SHALL have ports eviction_target_i (input, NUM_WAYS) and eviction_ready_i (input, 1), victim from the eviction policy.
REQ-010 SHALL have ports wb_valid (out, 1), wb_ready (in, 1), wb_way (out, WAY_IDX_W), writeback request.
REQ-011 SHALL have ports fill_valid (out, 1), fill_ready (in, 1), fill_way (out, WAY_IDX_W), line-fill request.
REQ-012 SHALL have ports resp_valid (out, 1), resp_ready (in, 1), resp_way (out, WAY_IDX_W), resp_hit (out, 1), completion response.
REQ-013 SHALL have ports busy (out, 1) and err_multi (out, 1, one-cycle pulse on a multi-hot hit or victim vector).

Function
REQ-014 SHALL implement FSM states IDLE, HIT_UPD, VICTIM, WB, FILL, ALLOC, RESP.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready.
REQ-016 On accept with nonzero req_hit_way SHALL go IDLE->HIT_UPD; with zero SHALL go IDLE->VICTIM.
REQ-017 In HIT_UPD SHALL drive hit_way_o = one-hot of the lowest set hit bit for exactly one cycle, then go to RESP with resp_hit=1 (resp_valid at accept+2).
REQ-018 In VICTIM SHALL wait while eviction_ready_i=0; when it is 1 SHALL capture the lowest set bit of eviction_target_i as the victim index and sample dirty_ways[victim].
REQ-019 Victim dirty SHALL go to WB; victim clean SHALL go directly to FILL.
REQ-020 In WB SHALL hold wb_valid=1 and wb_way stable until wb_ready=1, then go to FILL.
REQ-021 In FILL SHALL hold fill_valid=1 and fill_way stable until fill_ready=1, then go to ALLOC.
REQ-022 In ALLOC SHALL drive allocate_way_o = one-hot of the victim for exactly one cycle, then go to RESP with resp_hit=0.
REQ-023 In RESP SHALL hold resp_valid, resp_way and resp_hit stable until resp_ready=1, then return to IDLE (no same-cycle re-accept).
REQ-024 hit_way_o and allocate_way_o SHALL never be nonzero in the same cycle and SHALL be zero outside HIT_UPD and ALLOC respectively.
REQ-025 A multi-hot req_hit_way (at accept) or eviction_target_i (at capture) SHALL use the lowest set bit and pulse err_multi for one cycle.
REQ-026 wb_ready or fill_ready asserted outside WB or FILL SHALL be ignored.
REQ-027 busy SHALL be 1 in every state except IDLE.

Reset
REQ-028 When rst_n=0 at a clock edge SHALL enter IDLE and clear every output to 0, except req_ready, which is 1 from the first cycle after reset.
REQ-029 Reset mid-operation SHALL abandon any pending writeback, fill, update pulse or response without completing it.

Structure
REQ-030 Package cache_ctrl_pkg SHALL hold the FSM state enum and the default NUM_WAYS constant.
REQ-031 Sub-module onehot_prio_enc (NUM_WAYS -> lowest-set index plus multi-hot flag) SHALL be instantiated twice: for the hit vector and for the victim vector.

Verification (NUM_WAYS=8)
REQ-032 Hit: req_hit_way=8'h10 accepted at cycle T -> hit_way_o=8'h10 at T+1 only; resp_valid, resp_way=4, resp_hit=1 at T+2.
REQ-033 Clean miss: eviction_target_i=8'h04, dirty_ways=0 -> no wb_valid; fill_way=2; allocate_way_o=8'h04 for one cycle after fill_ready; resp_way=2, resp_hit=0.
REQ-034 Dirty miss with backpressure: target 8'h80, dirty_ways=8'h80, wb_ready low 5 cycles -> wb_valid and wb_way=7 held stable 5 cycles, then FILL, ALLOC, RESP.
REQ-035 Eviction not ready: eviction_ready_i low 3 cycles after a miss -> FSM stays in VICTIM, busy=1, no wb_valid or fill_valid.
REQ-036 Multi-hot: req_hit_way=8'h0A -> hit_way_o=8'h02, resp_way=1, err_multi pulsed one cycle.
REQ-037 Reset in FILL: rst_n=0 one cycle -> fill_valid=0 next cycle, req_ready=1 after release, no allocate_way_o or resp_valid.
